// File: rtl/ddr_seg_display.sv
// Seven-segment driver: latches a binary value, converts it to BCD one bit per clock
// (double-dabble), then scans the digits onto seg/an with LZ blanking and per-digit blink.
module ddr_seg_display #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned VAL_WIDTH   = 14,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [VAL_WIDTH-1:0]  value,
    input  logic                  load,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam int unsigned BcdW = 4 * NUM_DIGITS;
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned RefW = $clog2(REFRESH_DIV);
    localparam int unsigned BlkW = $clog2(BLINK_DIV);
    localparam int unsigned CntW = $clog2(VAL_WIDTH + 1);
    localparam logic [63:0] MaxVal = pow10(NUM_DIGITS) - 64'd1;

    typedef enum logic [0:0] {StIdle, StConv} state_e;
    state_e state_q, state_d;

    logic [VAL_WIDTH-1:0]  bin_q;
    logic [BcdW-1:0]       bcd_q, bcd_step;
    logic [CntW-1:0]       cnt_q;
    logic                  ovf_pend_q;
    logic [BcdW-1:0]       digits_q, digits_d;
    logic                  overflow_q, overflow_d;
    logic                  last_step, accept;

    logic [RefW-1:0]       ref_q, ref_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [BlkW-1:0]       blk_q, blk_d;
    logic                  phase_q, phase_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    assign accept    = (state_q == StIdle) && load;
    assign last_step = (state_q == StConv) && (cnt_q == CntW'(VAL_WIDTH - 1));

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (load)      state_d = StConv;
            StConv: if (last_step) state_d = StIdle;
            default:               state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q == StConv);
    end

    // One double-dabble step; digits above NUM_DIGITS are dropped since they never feed lower ones.
    always_comb begin
        logic [BcdW-1:0] adj;
        adj = bcd_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_step = {adj[BcdW-2:0], bin_q[VAL_WIDTH-1]};
    end

    always_comb begin
        digits_d   = digits_q;
        overflow_d = overflow_q;
        if (last_step) begin
            digits_d   = ovf_pend_q ? {NUM_DIGITS{4'd9}} : bcd_step;
            overflow_d = ovf_pend_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
            if (accept) begin
                bin_q      <= value;
                bcd_q      <= '0;
                cnt_q      <= '0;
                ovf_pend_q <= (64'(value) > MaxVal);
            end else if (state_q == StConv) begin
                bin_q <= bin_q << 1;
                bcd_q <= bcd_step;
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    // Scan/blink timing; seg/an are computed from post-edge state so both move together.
    always_comb begin
        logic ref_wrap, blk_wrap, lz_blank, bl_blank;
        ref_wrap = (ref_q == RefW'(REFRESH_DIV - 1));
        blk_wrap = (blk_q == BlkW'(BLINK_DIV - 1));
        ref_d    = ref_wrap ? '0 : ref_q + RefW'(1);
        blk_d    = blk_wrap ? '0 : blk_q + BlkW'(1);
        phase_d  = blk_wrap ? ~phase_q : phase_q;
        idx_d    = idx_q;
        if (ref_wrap) idx_d = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
        an_d     = ~(NUM_DIGITS'(1) << idx_d);
        // Digit is a leading zero when it and every digit above it are zero.
        lz_blank = blank_lz && (idx_d != '0) && ((digits_d >> {idx_d, 2'b00}) == '0);
        bl_blank = phase_d && blink_mask[idx_d];
        seg_d    = (lz_blank || bl_blank) ? 7'b1111111 : seg_pattern(digits_d[4*idx_d +: 4]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_q   <= '0;
            idx_q   <= '0;
            blk_q   <= '0;
            phase_q <= 1'b0;
            seg_q   <= 7'b1111111;
            an_q    <= '1;
        end else begin
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            blk_q   <= blk_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ddr_seg_display.sv
// Bench for ddr_seg_display: directed scenarios then random loads/masks/resets, every cycle
// compared against an arithmetic model of the displayed number and scan/blink timing.
module tb_ddr_seg_display;

    localparam int unsigned ND = 4;
    localparam int unsigned VW = 14;
    localparam int unsigned RD = 4;
    localparam int unsigned BD = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [VW-1:0] value = '0;
    logic          load = 1'b0;
    logic [ND-1:0] blink_mask = '0;
    logic          blank_lz = 1'b0;
    logic          busy, overflow;
    logic [6:0]    seg;
    logic [ND-1:0] an;

    ddr_seg_display #(
        .NUM_DIGITS (ND),
        .VAL_WIDTH  (VW),
        .REFRESH_DIV(RD),
        .BLINK_DIV  (BD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .value     (value),
        .load      (load),
        .blink_mask(blink_mask),
        .blank_lz  (blank_lz),
        .busy      (busy),
        .overflow  (overflow),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b expected=%b", tag, $time, got, exp);
        end
    endtask

    // Reference model: displayed number as an integer, timing from edges since reset.
    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    int p10 [5] = '{1, 10, 100, 1000, 10000};
    int t, mdig, mval, done_t, idx, phase, dg;
    bit mbusy, movf, bl;
    logic [6:0]    exp_seg;
    logic [ND-1:0] exp_an;
    logic          exp_busy, exp_ovf;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            t = 0; mdig = 0; mbusy = 0; movf = 0;
            exp_seg = 7'b1111111; exp_an = '1; exp_busy = 0; exp_ovf = 0;
        end else begin
            t++;
            if (mbusy) begin
                if (t == done_t) begin
                    mdig  = (mval > 9999) ? 9999 : mval;
                    movf  = (mval > 9999);
                    mbusy = 0;
                end
            end else if (load) begin
                mbusy  = 1;
                mval   = int'(value);
                done_t = t + VW;
            end
            idx   = (t / RD) % ND;
            phase = (t / BD) % 2;
            dg    = (mdig / p10[idx]) % 10;
            bl    = (blink_mask[idx] && phase == 1) || (blank_lz && idx > 0 && mdig < p10[idx]);
            exp_seg  = bl ? 7'b1111111 : pat[dg];
            exp_an   = ~(ND'(1) << idx);
            exp_busy = mbusy;
            exp_ovf  = movf;
        end
    end

    bit chk_en = 0;
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("seg", 32'(seg), 32'(exp_seg));
            check("an", 32'(an), 32'(exp_an));
            check("busy", 32'(busy), 32'(exp_busy));
            check("overflow", 32'(overflow), 32'(exp_ovf));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(input int v);
        load  = 1'b1;
        value = VW'(v);
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cycles(2);
        reset_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        chk_en = 1;
        do_reset();
        cycles(40);                          // idle scan showing 0000
        pulse_load(1234); cycles(30);
        blank_lz = 1'b1;
        pulse_load(7);    cycles(30);
        blank_lz = 1'b0;  cycles(20);
        pulse_load(12000); cycles(30);       // saturates to 9999
        pulse_load(5);    cycles(30);
        pulse_load(1234); cycles(2);
        pulse_load(42);   cycles(30);        // ignored while busy
        pulse_load(1234); cycles(5);
        do_reset();       cycles(20);        // aborted conversion
        blink_mask = 4'b0001;
        pulse_load(1234); cycles(70);
        blink_mask = 4'b0000;
        pulse_load(0); blank_lz = 1'b1; cycles(30);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            if ($urandom_range(0, 19) == 0) blink_mask = ND'($urandom);
            if ($urandom_range(0, 29) == 0) blank_lz = $urandom_range(0, 1) != 0;
            load = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       value = VW'($urandom_range(0, 9));
                1:       value = VW'($urandom_range(0, 999));
                2:       value = VW'($urandom_range(0, 9999));
                default: value = VW'($urandom);
            endcase
            @(negedge clk);
        end
        load   = 1'b0;
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
